sysref_monitor: RTL and testbench

Downstream consumer of the PL SYSREF capture stage in the `pl_clk` domain. Takes the registered `sysref_adc` level and detects its rising edges. It measures the period between edges against an expected value and tracks lock with a small state machine. Once locked, it produces a free-running, SYSREF-aligned frame strobe that PL datapath stages use for deterministic-latency alignment with the RF-ADC/RF-DAC.

---
 rtl/sysref_monitor.sv | 191 +++++++++++++++++++
 tb/tb_sysref_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sysref_monitor.sv
// SYSREF edge monitor: measures edge-to-edge period, tracks lock and emits a
// SYSREF-aligned frame strobe for deterministic-latency PL datapath alignment.
module sysref_monitor #(
  parameter int PERIOD   = 256,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             pl_clk,
  input  logic             pl_resetn,
  input  logic             sysref_adc,
  input  logic             arm,
  output logic             sysref_pulse,
  output logic [CNT_W-1:0] sysref_period,
  output logic             lmfc_strobe,
  output logic             locked,
  output logic [1:0]       state,
  output logic             edge_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LO    = CNT_W'((TOL >= PERIOD) ? 0 : PERIOD - TOL);
  localparam logic [CNT_W-1:0] GAP_HI    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] GAP_MISS  = CNT_W'(PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] LMFC_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = CNT_W'(0);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_CNT);

  logic             prev_q;
  logic             pulse_q,      pulse_d;
  logic [CNT_W-1:0] gap_q,        gap_d;
  logic [CNT_W-1:0] period_q,     period_d;
  state_t           state_q,      state_d;
  logic [3:0]       good_cnt_q,   good_cnt_d;
  logic             first_seen_q, first_seen_d;
  logic             edge_err_q,   edge_err_d;
  logic [7:0]       err_count_q,  err_count_d;
  logic [CNT_W-1:0] lmfc_cnt_q,   lmfc_cnt_d;
  logic             strobe_q,     strobe_d;
  logic             locked_q,     locked_d;

  logic edge_s;
  logic good_s;
  logic missing_s;
  logic log_err_s;
  logic enter_lock_s;

  assign edge_s    = sysref_adc & ~prev_q;
  assign good_s    = (gap_q >= GAP_LO) && (gap_q <= GAP_HI);
  assign missing_s = first_seen_q && (gap_q == GAP_MISS);

  // Period measurement: gap counts cycles since the last edge, saturating.
  always_comb begin
    pulse_d  = edge_s;
    gap_d    = gap_q;
    period_d = period_q;
    if (edge_s) begin
      period_d = gap_q;
      gap_d    = ONE;
    end else if (gap_q != {CNT_W{1'b1}}) begin
      gap_d = gap_q + ONE;
    end else begin
      gap_d = gap_q;
    end
  end

  // Lock FSM next state; arm wins over any edge seen in the same cycle.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    first_seen_d = first_seen_q;
    edge_err_d   = edge_err_q;
    err_count_d  = err_count_q;
    log_err_s    = 1'b0;
    enter_lock_s = 1'b0;
    if (arm) begin
      state_d      = ST_ACQUIRE;
      good_cnt_d   = 4'd0;
      first_seen_d = 1'b0;
      edge_err_d   = 1'b0;
      err_count_d  = 8'd0;
    end else begin
      case (state_q)
        ST_ACQUIRE: begin
          if (edge_s) begin
            if (!first_seen_q) begin
              first_seen_d = 1'b1;
            end else if (good_s) begin
              if (good_cnt_q + 4'd1 == LOCK_N) begin
                state_d      = ST_LOCKED;
                good_cnt_d   = 4'd0;
                enter_lock_s = 1'b1;
              end else begin
                good_cnt_d = good_cnt_q + 4'd1;
              end
            end else begin
              good_cnt_d = 4'd0;
              log_err_s  = 1'b1;
            end
          end else if (missing_s) begin
            good_cnt_d = 4'd0;
            log_err_s  = 1'b1;
          end else begin
            good_cnt_d = good_cnt_q;
          end
        end
        ST_LOCKED: begin
          if ((edge_s && !good_s) || (!edge_s && missing_s)) begin
            state_d   = ST_LOST;
            log_err_s = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: state_d = state_q;
      endcase
      if (log_err_s) begin
        edge_err_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end else begin
          err_count_d = err_count_q;
        end
      end else begin
        edge_err_d = edge_err_q;
      end
    end
  end

  // Frame counter re-aligns to every edge while locked; strobe looks ahead one cycle.
  always_comb begin
    lmfc_cnt_d = lmfc_cnt_q;
    if (enter_lock_s || (state_q == ST_LOCKED && edge_s)) begin
      lmfc_cnt_d = ZERO;
    end else if (lmfc_cnt_q >= LMFC_LAST) begin
      lmfc_cnt_d = ZERO;
    end else begin
      lmfc_cnt_d = lmfc_cnt_q + ONE;
    end
    locked_d = (state_d == ST_LOCKED);
    strobe_d = (lmfc_cnt_d == ZERO) && locked_d;
  end

  // State and output registers.
  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      prev_q       <= 1'b0;
      pulse_q      <= 1'b0;
      gap_q        <= ZERO;
      period_q     <= ZERO;
      state_q      <= ST_IDLE;
      good_cnt_q   <= 4'd0;
      first_seen_q <= 1'b0;
      edge_err_q   <= 1'b0;
      err_count_q  <= 8'd0;
      lmfc_cnt_q   <= ZERO;
      strobe_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      prev_q       <= sysref_adc;
      pulse_q      <= pulse_d;
      gap_q        <= gap_d;
      period_q     <= period_d;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      first_seen_q <= first_seen_d;
      edge_err_q   <= edge_err_d;
      err_count_q  <= err_count_d;
      lmfc_cnt_q   <= lmfc_cnt_d;
      strobe_q     <= strobe_d;
      locked_q     <= locked_d;
    end
  end

  assign sysref_pulse  = pulse_q;
  assign sysref_period = period_q;
  assign lmfc_strobe   = strobe_q;
  assign locked        = locked_q;
  assign state         = state_q;
  assign edge_err      = edge_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_sysref_monitor.sv
// Scoreboard bench for sysref_monitor: expected per-edge responses are queued
// by the stimulus and checked by a monitor on every sysref_pulse.
module tb_sysref_monitor;

  localparam int CNT_W = 16;

  logic             pl_clk;
  logic             pl_resetn;
  logic             sysref_adc;
  logic             arm;
  logic             sysref_pulse;
  logic [CNT_W-1:0] sysref_period;
  logic             lmfc_strobe;
  logic             locked;
  logic [1:0]       state;
  logic             edge_err;
  logic [7:0]       err_count;

  sysref_monitor #(.PERIOD(256), .TOL(1), .LOCK_CNT(4), .CNT_W(CNT_W)) dut (
    .pl_clk       (pl_clk),
    .pl_resetn    (pl_resetn),
    .sysref_adc   (sysref_adc),
    .arm          (arm),
    .sysref_pulse (sysref_pulse),
    .sysref_period(sysref_period),
    .lmfc_strobe  (lmfc_strobe),
    .locked       (locked),
    .state        (state),
    .edge_err     (edge_err),
    .err_count    (err_count)
  );

  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  typedef struct {
    bit chk_per;
    int per;
    bit strobe;
    bit lck;
    int st;
    int err;
    bit eerr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;
  int   s0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"},  {31'd0, sysref_pulse}, 32'd0);
    chk({tag, "_period"}, {16'd0, sysref_period}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, lmfc_strobe}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_state"},  {30'd0, state}, 32'd0);
    chk({tag, "_eerr"},   {31'd0, edge_err}, 32'd0);
    chk({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
  endtask

  task automatic cyc(input logic a, input logic r);
    sysref_adc = a;
    arm        = r;
    @(posedge pl_clk);
    #1;
  endtask

  // Edge arriving p cycles after the previous edge, with its expected response.
  task automatic edge_after(input int p, input logic r, input bit chk_per, input int per,
                            input bit strobe, input bit lck, input int st, input int err,
                            input bit eerr);
    exp_t e;
    repeat (p - 1) cyc(1'b0, 1'b0);
    e.chk_per = chk_per; e.per = per; e.strobe = strobe; e.lck = lck;
    e.st = st; e.err = err; e.eerr = eerr;
    exp_q.push_back(e);
    cyc(1'b1, r);
  endtask

  // Monitor: counts strobes and checks each pulse against the scoreboard.
  always @(negedge pl_clk) begin
    if (pl_resetn) begin
      if (lmfc_strobe) strobe_cnt++;
      if (sysref_pulse) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got pulse expected none (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk_per) chk("pulse_period", {16'd0, sysref_period}, mon_e.per);
          chk("pulse_strobe", {31'd0, lmfc_strobe}, {31'd0, mon_e.strobe});
          chk("pulse_locked", {31'd0, locked}, {31'd0, mon_e.lck});
          chk("pulse_state",  {30'd0, state}, mon_e.st);
          chk("pulse_errcnt", {24'd0, err_count}, mon_e.err);
          chk("pulse_eerr",   {31'd0, edge_err}, {31'd0, mon_e.eerr});
        end
      end
    end
  end

  initial begin
    sysref_adc = 1'b0;
    arm        = 1'b0;
    pl_resetn  = 1'b1;
    #2 pl_resetn = 1'b0;
    repeat (3) @(posedge pl_clk);
    #1;
    chk_zero("in_reset");
    pl_resetn = 1'b1;
    repeat (20) cyc(1'b0, 1'b0);
    chk_zero("idle");

    // Lock: 1 first edge + 4 good edges.
    cyc(1'b0, 1'b1);
    chk("arm_state", {30'd0, state}, 32'd1);
    edge_after(10, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    repeat (3) edge_after(256, 1'b0, 1'b1, 256, 1'b0, 1'b0, 1, 0, 1'b0);
    edge_after(256, 1'b0, 1'b1, 256, 1'b1, 1'b1, 2, 0, 1'b0);
    @(negedge pl_clk);
    #1;
    s0 = strobe_cnt;
    edge_after(256, 1'b0, 1'b1, 256, 1'b1, 1'b1, 2, 0, 1'b0);
    @(negedge pl_clk);
    #1;
    chk("strobe_spacing", strobe_cnt - s0, 32'd1);

    // Tolerance window.
    edge_after(255, 1'b0, 1'b1, 255, 1'b1, 1'b1, 2, 0, 1'b0);
    edge_after(257, 1'b0, 1'b1, 257, 1'b1, 1'b1, 2, 0, 1'b0);
    edge_after(258, 1'b0, 1'b1, 258, 1'b0, 1'b0, 3, 1, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    chk("lost_hold_state", {30'd0, state}, 32'd3);

    // Re-arm on an edge cycle: that edge must not count as first.
    edge_after(251, 1'b1, 1'b1, 256, 1'b0, 1'b0, 1, 0, 1'b0);
    repeat (4) edge_after(256, 1'b0, 1'b1, 256, 1'b0, 1'b0, 1, 0, 1'b0);
    edge_after(256, 1'b0, 1'b1, 256, 1'b1, 1'b1, 2, 0, 1'b0);

    // Missing edge.
    repeat (257) cyc(1'b0, 1'b0);
    chk("pre_missing_state", {30'd0, state}, 32'd2);
    chk("pre_missing_err",   {24'd0, err_count}, 32'd0);
    cyc(1'b0, 1'b0);
    chk("missing_state",  {30'd0, state}, 32'd3);
    chk("missing_err",    {24'd0, err_count}, 32'd1);
    chk("missing_eerr",   {31'd0, edge_err}, 32'd1);
    chk("missing_locked", {31'd0, locked}, 32'd0);
    repeat (300) cyc(1'b0, 1'b0);
    chk("missing_err_hold", {24'd0, err_count}, 32'd1);

    // Lock with a bad edge in acquisition, then async reset mid-period.
    cyc(1'b0, 1'b1);
    edge_after(10, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    repeat (2) edge_after(256, 1'b0, 1'b1, 256, 1'b0, 1'b0, 1, 0, 1'b0);
    edge_after(200, 1'b0, 1'b1, 200, 1'b0, 1'b0, 1, 1, 1'b1);
    repeat (3) edge_after(256, 1'b0, 1'b1, 256, 1'b0, 1'b0, 1, 1, 1'b1);
    edge_after(256, 1'b0, 1'b1, 256, 1'b1, 1'b1, 2, 1, 1'b1);
    repeat (100) cyc(1'b0, 1'b0);
    chk("pre_reset_locked", {31'd0, locked}, 32'd1);
    chk("pre_reset_err",    {24'd0, err_count}, 32'd1);
    #2;
    pl_resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge pl_clk);
    #1;
    pl_resetn = 1'b1;
    repeat (5) cyc(1'b0, 1'b0);
    chk("post_reset_state", {30'd0, state}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
